sreg_frame: RTL and testbench

Parametrised serial-in/parallel-out frame register: the successor to the fixed 21-bit shift register in the CPLD. It sits between the MCU serial link and the cartridge address bus. It shifts in a framed serial word and commits it to a double-buffered parallel output only when the frame is complete. It also provides auto-increment of the committed word for sequential bus accesses.

---
 rtl/sreg_pkg.sv | 16 +
 rtl/sreg_frame.sv | 145 ++++++++++++++
 tb/tb_sreg_frame.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sreg_pkg.sv
// Shared types and helpers for the serial-in/parallel-out frame register.
package sreg_pkg;

  // Frame receiver states: waiting for a frame, collecting bits, word complete.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Width of a counter that must hold every value from 0 up to dwidth inclusive.
  function automatic int cnt_width(input int dwidth);
    return $clog2(dwidth + 1);
  endfunction

endpackage : sreg_pkg

// File: rtl/sreg_frame.sv
// Framed serial-in/parallel-out register with a double-buffered committed word.
// Bits are collected while en_n is low; the committed word only changes when a
// complete frame has been received, or when an increment request arrives.
module sreg_frame
  import sreg_pkg::*;
#(
  parameter int               DWIDTH      = 21,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter logic [DWIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_n,
  input  logic              sdin,
  input  logic              sstb,
  input  logic              inc,
  output logic [DWIDTH-1:0] out,
  output logic              valid,
  output logic              done,
  output logic              short,
  output logic              ovr
);

  localparam int             CW       = cnt_width(DWIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DWIDTH - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DWIDTH);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [DWIDTH-1:0]   buf_q,   buf_d;
  logic [DWIDTH-1:0]   out_q,   out_d;
  logic                valid_q, valid_d;
  logic                done_q,  done_d;
  logic                short_q, short_d;
  logic                ovr_q,   ovr_d;

  logic [DWIDTH-1:0]   shift_word;
  logic                commit;

  // Buffer contents after shifting in the current serial bit.
  always_comb begin
    if (MSB_FIRST) begin
      shift_word = {buf_q[DWIDTH-2:0], sdin};
    end else begin
      shift_word = {sdin, buf_q[DWIDTH-1:1]};
    end
  end

  // Next-state, buffer, counter and output-pulse logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    short_d = 1'b0;
    ovr_d   = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!en_n) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        // Frame end wins over a strobe arriving in the same cycle.
        if (en_n) begin
          state_d = IDLE;
          if (cnt_q != '0) begin
            short_d = 1'b1;
          end
        end else if (sstb) begin
          buf_d = shift_word;
          if (cnt_q == LAST_CNT) begin
            commit  = 1'b1;
            cnt_d   = FULL_CNT;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      FULL: begin
        if (en_n) begin
          state_d = IDLE;
        end else if (sstb) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A completed frame overrides a coincident increment request.
    if (commit) begin
      out_d   = shift_word;
      valid_d = 1'b1;
      done_d  = 1'b1;
    end else if (inc) begin
      out_d = out_q + 1'b1;
    end
  end

  // State, buffer and registered outputs; everything returns to reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= RESET_VALUE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every register see the pre-edge values
      // of the others, which is what the next-state logic was written against.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      short_q <= short_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign short = short_q;
  assign ovr   = ovr_q;

endmodule : sreg_frame

// File: tb/tb_sreg_frame.sv
// Randomized and directed bench for sreg_frame. Two instances share the serial
// stimulus: one shifting MSB first, one LSB first. A frame-level model (bit
// queue plus assembled words) predicts every output after every clock edge.
module tb_sreg_frame;

  localparam int          D    = 21;
  localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_n, sdin, sstb, inc;
  logic [D-1:0] out_m, out_l;
  logic         valid_m, done_m, short_m, ovr_m;
  logic         valid_l, done_l, short_l, ovr_l;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int short_cnt = 0;
  int ovr_cnt = 0;

  // Reference model state.
  bit          active;
  bit          bits[$];
  logic [31:0] m_out_m, m_out_l;
  bit          m_valid, m_done, m_short, m_ovr;

  sreg_frame #(.DWIDTH(D), .MSB_FIRST(1'b1), .RESET_VALUE('0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .sdin(sdin), .sstb(sstb), .inc(inc),
    .out(out_m), .valid(valid_m), .done(done_m), .short(short_m), .ovr(ovr_m)
  );

  sreg_frame #(.DWIDTH(D), .MSB_FIRST(1'b0), .RESET_VALUE('0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .sdin(sdin), .sstb(sstb), .inc(inc),
    .out(out_l), .valid(valid_l), .done(done_l), .short(short_l), .ovr(ovr_l)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word formed by the received bits: first bit at the top or at bit 0.
  function automatic logic [31:0] assemble(input bit msb);
    logic [31:0] w = '0;
    for (int i = 0; i < bits.size(); i++) begin
      if (bits[i]) w = w | (32'd1 << (msb ? (D - 1 - i) : i));
    end
    return w;
  endfunction

  task automatic model_reset();
    active  = 1'b0;
    bits.delete();
    m_out_m = '0;
    m_out_l = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_short = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_update(input bit en, input bit sd, input bit st, input bit ic);
    bit commit = 1'b0;
    m_done  = 1'b0;
    m_short = 1'b0;
    m_ovr   = 1'b0;
    if (!active) begin
      if (!en) begin
        active = 1'b1;
        bits.delete();
      end
    end else if (en) begin
      if (bits.size() > 0 && bits.size() < D) m_short = 1'b1;
      active = 1'b0;
    end else if (st) begin
      if (bits.size() == D) begin
        m_ovr = 1'b1;
      end else begin
        bits.push_back(sd);
        if (bits.size() == D) begin
          commit  = 1'b1;
          m_out_m = assemble(1'b1);
          m_out_l = assemble(1'b0);
          m_valid = 1'b1;
          m_done  = 1'b1;
        end
      end
    end
    if (ic && !commit) begin
      m_out_m = (m_out_m + 32'd1) & MASK;
      m_out_l = (m_out_l + 32'd1) & MASK;
    end
  endtask

  task automatic compare_all();
    check("out_msb",   32'(out_m),   m_out_m);
    check("valid_msb", 32'(valid_m), 32'(m_valid));
    check("done_msb",  32'(done_m),  32'(m_done));
    check("short_msb", 32'(short_m), 32'(m_short));
    check("ovr_msb",   32'(ovr_m),   32'(m_ovr));
    check("out_lsb",   32'(out_l),   m_out_l);
    check("done_lsb",  32'(done_l),  32'(m_done));
    check("short_lsb", 32'(short_l), 32'(m_short));
    check("ovr_lsb",   32'(ovr_l),   32'(m_ovr));
    check("valid_lsb", 32'(valid_l), 32'(m_valid));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input bit en, input bit sd, input bit st, input bit ic);
    en_n = en;
    sdin = sd;
    sstb = st;
    inc  = ic;
    @(posedge clk);
    model_update(en, sd, st, ic);
    #1;
    done_cnt  += int'(done_m);
    short_cnt += int'(short_m);
    ovr_cnt   += int'(ovr_m);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_n  = 1'b1;
    sdin  = 1'b0;
    sstb  = 1'b0;
    inc   = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Open a frame, shift nbits of word (top bit first), optionally close it.
  task automatic send_frame(input logic [31:0] word, input int nbits,
                            input bit inc_last, input bit close_frame);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      step(1'b0, word[D-1-i], 1'b1, inc_last && (i == nbits - 1));
    end
    if (close_frame) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int d0, s0, o0;
    en_n = 1'b1; sdin = 1'b0; sstb = 1'b0; inc = 1'b0; rst_n = 1'b0;
    model_reset();
    do_reset();
    check("reset_out", 32'(out_m), 32'h0);
    check("reset_valid", 32'(valid_m), 32'h0);

    // First bit 1, rest 0: LSB-first instance sees 0x000001.
    send_frame(32'h100000, D, 1'b0, 1'b1);
    check("lsb_first_out", 32'(out_l), 32'h000001);
    check("msb_first_out", 32'(out_m), 32'h100000);

    // Full frame commit.
    d0 = done_cnt;
    send_frame(32'h1ABCDE, D, 1'b0, 1'b0);
    check("frame_out", 32'(out_m), 32'h1ABCDE);
    check("frame_valid", 32'(valid_m), 32'h1);
    check("frame_done_now", 32'(done_m), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("frame_done_once", 32'(done_cnt - d0), 32'd1);

    // Short frame of 8 bits.
    d0 = done_cnt; s0 = short_cnt;
    send_frame(32'h0F0F0F, 8, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("short_once", 32'(short_cnt - s0), 32'd1);
    check("short_no_done", 32'(done_cnt - d0), 32'd0);
    check("short_keeps_out", 32'(out_m), 32'h1ABCDE);

    // All-ones frame, increment wraps, then overrun strobes.
    send_frame(32'h1FFFFF, D, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("inc_wrap", 32'(out_m), 32'h000000);
    o0 = ovr_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_three", 32'(ovr_cnt - o0), 32'd3);
    check("ovr_keeps_out", 32'(out_m), 32'h000000);

    // Increment coincident with the final strobe is dropped.
    send_frame(32'h000010, D, 1'b1, 1'b1);
    check("inc_vs_commit", 32'(out_m), 32'h000010);

    // Reset in the middle of a frame: no pulse, then a clean frame.
    s0 = short_cnt;
    send_frame(32'h155555, 10, 1'b0, 1'b0);
    do_reset();
    check("midreset_out", 32'(out_m), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(32'h000100, D, 1'b0, 1'b1);
    check("after_reset_out", 32'(out_m), 32'h000100);
    check("reset_no_short", 32'(short_cnt - s0), 32'd0);

    // Randomized frames: random lengths, gaps, increments, early ends, resets.
    for (int f = 0; f < 250; f++) begin
      int len = $urandom_range(0, D + 3);
      step(1'b0, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      for (int b = 0; b < len; b++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 1'($urandom), 1'b0, ($urandom_range(0, 5) == 0));
        end
        step(1'b0, 1'($urandom), 1'b1, ($urandom_range(0, 5) == 0));
      end
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end
      step(1'b1, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step(1'b1, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sreg_frame
